// File: rtl/vcve2_dmem_pkg.sv
// Shared request/response types and the rotating priority picker used by the
// data-memory crossbar arbiters.
package vcve2_dmem_pkg;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } dmem_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } dmem_rsp_t;

   // Picker handles up to 32 requesters.
   localparam int unsigned PickIdxW = 5;

   typedef struct packed {
      logic                found;
      logic [PickIdxW-1:0] idx;
   } pick_t;

   // First set bit of mask[n-1:0], searching upward from start and wrapping.
   function automatic pick_t prio_pick(input logic [31:0]         mask,
                                       input logic [PickIdxW-1:0] start,
                                       input int unsigned         n);
      pick_t               res;
      logic [PickIdxW-1:0] c;
      res = '0;
      for (int unsigned k = 0; k < 32; k++) begin
         if (k < n) begin
            c = PickIdxW'((32'(start) + k) % n);
            if (!res.found && mask[c]) begin
               res.found = 1'b1;
               res.idx   = c;
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/vcve2_dmem_rsp_fifo.sv
// Circular FIFO of requester IDs; remembers who owns each outstanding access
// on one memory port so responses can be routed back in order.
module vcve2_dmem_rsp_fifo #(
   parameter int unsigned  Depth = 2,
   parameter int unsigned  Width = 1,
   localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1,
   localparam int unsigned CntW  = $clog2(Depth + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [Width-1:0] head_o
);

   logic [Width-1:0] mem_r [Depth];
   logic [PtrW-1:0]  wr_ptr_r;
   logic [PtrW-1:0]  rd_ptr_r;
   logic [CntW-1:0]  cnt_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
      logic [PtrW-1:0] nxt;
      if (ptr == PtrW'(Depth - 1)) begin
         nxt = '0;
      end else begin
         nxt = ptr + PtrW'(1);
      end
      return nxt;
   endfunction

   assign full_o    = (cnt_r == CntW'(Depth));
   assign empty_o   = (cnt_r == CntW'(0));
   assign head_o    = mem_r[rd_ptr_r];
   assign push_ok_s = push_i & ~full_o;
   assign pop_ok_s  = pop_i & ~empty_o;

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         cnt_r    <= '0;
      end else begin
         wr_ptr_r <= push_ok_s ? next_ptr(wr_ptr_r) : wr_ptr_r;
         rd_ptr_r <= pop_ok_s ? next_ptr(rd_ptr_r) : rd_ptr_r;
         case ({push_ok_s, pop_ok_s})
            2'b10:   cnt_r <= cnt_r + CntW'(1);
            2'b01:   cnt_r <= cnt_r - CntW'(1);
            default: cnt_r <= cnt_r;
         endcase
      end
   end

   // ID storage.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned k = 0; k < Depth; k++) begin
            mem_r[k] <= '0;
         end
      end else if (push_ok_s) begin
         mem_r[wr_ptr_r] <= data_i;
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

endmodule

// File: rtl/vcve2_dmem_xbar_chk.sv
// Protocol checks for the crossbar: a requester must never receive responses
// from two ports in the same cycle (it broke the one-port-at-a-time rule).
module vcve2_dmem_xbar_chk #(
   parameter int unsigned NumReq   = 2,
   parameter int unsigned NumPorts = 1
) (
   input logic                               clk_i,
   input logic                               rst_i,
   input logic [NumReq-1:0][NumPorts-1:0]    rsp_hit_i
);

   for (genvar i = 0; i < NumReq; i++) begin : g_req
      a_one_port_rsp: assert property (@(posedge clk_i) disable iff (rst_i)
                                       $onehot0(rsp_hit_i[i]));
   end

endmodule

// File: rtl/vcve2_dmem_xbar.sv
// Data-memory crossbar: NumReq requesters (0 = LSU) onto NumPorts memory ports
// with grant locking and in-order response routing. Define
// VCVE2_DMEM_XBAR_RR_ARB_EN for per-port round-robin instead of fixed priority.
module vcve2_dmem_xbar
   import vcve2_dmem_pkg::*;
#(
   parameter int unsigned  NumReq         = 2,
   parameter int unsigned  NumPorts       = 1,
   parameter int unsigned  MaxOutstanding = 2,
   localparam int unsigned ReqIdW         = (NumReq > 1) ? $clog2(NumReq) : 1,
   localparam int unsigned PortIdW        = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic      [NumReq-1:0]              req_valid_i,
   input  logic      [NumReq-1:0][PortIdW-1:0] req_port_i,
   input  dmem_req_t [NumReq-1:0]              req_i,
   output logic      [NumReq-1:0]              req_gnt_o,
   output logic      [NumReq-1:0]              rsp_valid_o,
   output dmem_rsp_t [NumReq-1:0]              rsp_o,
   output logic      [NumPorts-1:0]            data_req_o,
   output dmem_req_t [NumPorts-1:0]            data_o,
   input  logic      [NumPorts-1:0]            data_gnt_i,
   input  logic      [NumPorts-1:0]            data_rvalid_i,
   input  dmem_rsp_t [NumPorts-1:0]            data_rsp_i,
   output logic                             proto_err_o
);

   logic [NumPorts-1:0]             port_push_s;
   logic [NumPorts-1:0]             port_pop_s;
   logic [NumPorts-1:0]             port_err_s;
   logic [NumPorts-1:0][ReqIdW-1:0] port_sel_s;
   logic [NumPorts-1:0][ReqIdW-1:0] port_head_s;
   logic [NumReq-1:0][NumPorts-1:0] rsp_hit_s;
   logic                            proto_err_r;

   for (genvar p = 0; p < NumPorts; p++) begin : g_port
      logic [NumReq-1:0] cand_s;
      pick_t             pick_s;
      logic [ReqIdW-1:0] start_s;
      logic [ReqIdW-1:0] sel_s;
      logic              sel_vld_s;
      logic              req_s;
      logic              full_s;
      logic              empty_s;
      logic [ReqIdW-1:0] head_s;
      logic              owner_vld_r;
      logic [ReqIdW-1:0] owner_id_r;

      // Requesters currently asking for this port.
      always_comb begin
         cand_s = '0;
         for (int unsigned i = 0; i < NumReq; i++) begin
            if (req_valid_i[i] && (req_port_i[i] == PortIdW'(p))) begin
               cand_s[i] = 1'b1;
            end else begin
               cand_s[i] = 1'b0;
            end
         end
      end

`ifdef VCVE2_DMEM_XBAR_RR_ARB_EN
      logic [ReqIdW-1:0] rr_ptr_r;

      assign start_s = rr_ptr_r;

      // Round-robin pointer advances past whoever was just granted.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            rr_ptr_r <= '0;
         end else if (port_push_s[p]) begin
            rr_ptr_r <= (sel_s == ReqIdW'(NumReq - 1)) ? '0 : sel_s + ReqIdW'(1);
         end else begin
            rr_ptr_r <= rr_ptr_r;
         end
      end
`else
      assign start_s = '0;
`endif

      assign pick_s = prio_pick(32'(cand_s), PickIdxW'(start_s), NumReq);

      // A locked owner keeps the port until granted; if it withdraws, the
      // lock falls away and normal arbitration resumes.
      always_comb begin
         if (owner_vld_r && cand_s[owner_id_r]) begin
            sel_s     = owner_id_r;
            sel_vld_s = 1'b1;
         end else begin
            sel_s     = ReqIdW'(pick_s.idx);
            sel_vld_s = pick_s.found;
         end
      end

      assign req_s          = sel_vld_s & ~full_s & ~rst_i;
      assign port_push_s[p] = req_s & data_gnt_i[p];
      assign port_pop_s[p]  = data_rvalid_i[p] & ~empty_s & ~rst_i;
      assign port_err_s[p]  = data_rvalid_i[p] & empty_s;
      assign port_sel_s[p]  = sel_s;
      assign port_head_s[p] = head_s;
      assign data_req_o[p]  = req_s;
      assign data_o[p]      = req_i[sel_s];

      // Grant lock: remember a presented-but-stalled winner.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            owner_vld_r <= 1'b0;
            owner_id_r  <= '0;
         end else if (req_s && !data_gnt_i[p]) begin
            owner_vld_r <= 1'b1;
            owner_id_r  <= sel_s;
         end else begin
            owner_vld_r <= 1'b0;
            owner_id_r  <= owner_id_r;
         end
      end

      vcve2_dmem_rsp_fifo #(
         .Depth (MaxOutstanding),
         .Width (ReqIdW)
      ) u_rsp_fifo (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .push_i  (port_push_s[p]),
         .data_i  (sel_s),
         .pop_i   (port_pop_s[p]),
         .full_o  (full_s),
         .empty_o (empty_s),
         .head_o  (head_s)
      );
   end

   // Fold per-port grants and responses back onto each requester.
   always_comb begin
      req_gnt_o   = '0;
      rsp_valid_o = '0;
      rsp_o       = '0;
      rsp_hit_s   = '0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         for (int unsigned p = 0; p < NumPorts; p++) begin
            rsp_hit_s[i][p] = port_pop_s[p] && (port_head_s[p] == ReqIdW'(i));
            req_gnt_o[i]    = req_gnt_o[i] |
                              (port_push_s[p] && (port_sel_s[p] == ReqIdW'(i)));
            rsp_valid_o[i]  = rsp_valid_o[i] | rsp_hit_s[i][p];
            rsp_o[i]        = dmem_rsp_t'(rsp_o[i] |
                              (data_rsp_i[p] & {$bits(dmem_rsp_t){rsp_hit_s[i][p]}}));
         end
      end
   end

   // Sticky flag for responses arriving with nothing outstanding.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         proto_err_r <= 1'b0;
      end else begin
         proto_err_r <= proto_err_r | (|port_err_s);
      end
   end

   assign proto_err_o = proto_err_r;

   vcve2_dmem_xbar_chk #(
      .NumReq   (NumReq),
      .NumPorts (NumPorts)
   ) u_chk (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .rsp_hit_i (rsp_hit_s)
   );

endmodule
